// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side signal bundle for the shared-ALU arbiter.
interface alu_share_arbiter_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned SH_W   = 5;
  localparam int unsigned NREQ   = 2;

  // requester side
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [OP_W-1:0]   req_opcode0;
  logic [OP_W-1:0]   req_opcode1;
  logic [SH_W-1:0]   req_shamt0;
  logic [SH_W-1:0]   req_shamt1;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_b1;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ-1:0]   resp_ready;
  logic [DATA_W-1:0] resp_result0;
  logic [DATA_W-1:0] resp_result1;
  logic              resp_ne0;
  logic              resp_ne1;
  logic              resp_lt0;
  logic              resp_lt1;
  logic              resp_ovf0;
  logic              resp_ovf1;

  // ALU side
  logic [DATA_W-1:0] alu_operandA;
  logic [DATA_W-1:0] alu_operandB;
  logic [OP_W-1:0]   alu_opcode;
  logic [SH_W-1:0]   alu_shiftamt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_isNotEqual;
  logic              alu_isLessThan;
  logic              alu_overflow;

  // arbiter view
  modport slave (
    input  req_valid, req_opcode0, req_opcode1, req_shamt0, req_shamt1,
           req_a0, req_a1, req_b0, req_b1, resp_ready,
           alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    output req_ready, resp_valid, resp_result0, resp_result1,
           resp_ne0, resp_ne1, resp_lt0, resp_lt1, resp_ovf0, resp_ovf1,
           alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );

  // requesters plus ALU view
  modport master (
    output req_valid, req_opcode0, req_opcode1, req_shamt0, req_shamt1,
           req_a0, req_a1, req_b0, req_b1, resp_ready,
           alu_result, alu_isNotEqual, alu_isLessThan, alu_overflow,
    input  req_ready, resp_valid, resp_result0, resp_result1,
           resp_ne0, resp_ne1, resp_lt0, resp_lt1, resp_ovf0, resp_ovf1,
           alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; one op in flight,
// results parked in a per-requester buffer until consumed.
module alu_share_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0
) (
  input logic               clock,
  input logic               reset_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       handshake;
  logic       win;
  logic       owner;
  logic       last_grant;
  logic [1:0] capture_mask;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, EXEC always returns after one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = EXEC;
      EXEC:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and ready; a requester with an unconsumed response is skipped
  always_comb begin
    eligible  = bus.req_valid & ~bus.resp_valid;
    grant     = 2'b00;
    if (state == IDLE) begin
      case (eligible)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
          if (PRIORITY_MODE == 1) grant = 2'b01;
          else                    grant = last_grant ? 2'b01 : 2'b10;
        end
        default: grant = 2'b00;
      endcase
    end
    bus.req_ready = grant & {2{reset_n}};
    handshake     = |(bus.req_valid & bus.req_ready);
    win           = bus.req_ready[1];
    capture_mask  = (state == EXEC) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end

  // ALU operand registers, loaded from the winner on handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.alu_operandA <= '0;
      bus.alu_operandB <= '0;
      bus.alu_opcode   <= '0;
      bus.alu_shiftamt <= '0;
    end else if (handshake) begin
      bus.alu_operandA <= win ? bus.req_a1      : bus.req_a0;
      bus.alu_operandB <= win ? bus.req_b1      : bus.req_b0;
      bus.alu_opcode   <= win ? bus.req_opcode1 : bus.req_opcode0;
      bus.alu_shiftamt <= win ? bus.req_shamt1  : bus.req_shamt0;
    end
  end

  // Owner of the in-flight op and round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (handshake) begin
      owner      <= win;
      last_grant <= win;
    end
  end

  // Response valid bits: set on capture, cleared on consumption
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_valid <= 2'b00;
    end else begin
      bus.resp_valid <= (bus.resp_valid & ~bus.resp_ready) | capture_mask;
    end
  end

  // Response payload buffers, written only when their owner's op completes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_result0 <= '0;
      bus.resp_ne0     <= 1'b0;
      bus.resp_lt0     <= 1'b0;
      bus.resp_ovf0    <= 1'b0;
      bus.resp_result1 <= '0;
      bus.resp_ne1     <= 1'b0;
      bus.resp_lt1     <= 1'b0;
      bus.resp_ovf1    <= 1'b0;
    end else begin
      if (capture_mask[0]) begin
        bus.resp_result0 <= bus.alu_result;
        bus.resp_ne0     <= bus.alu_isNotEqual;
        bus.resp_lt0     <= bus.alu_isLessThan;
        bus.resp_ovf0    <= bus.alu_overflow;
      end
      if (capture_mask[1]) begin
        bus.resp_result1 <= bus.alu_result;
        bus.resp_ne1     <= bus.alu_isNotEqual;
        bus.resp_lt1     <= bus.alu_isLessThan;
        bus.resp_ovf1    <= bus.alu_overflow;
      end
    end
  end

endmodule
